// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared decode constants, branch-kind enum and predictor counter constants
// used by the branch resolve / predict slice.
// No ports (package).
// ---------------------------------------------------------------------------
package branch_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    // SPECIAL funct codes (instr[5:0])
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // REGIMM rt selectors (instr[20:16])
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    typedef enum logic [3:0] {
        BR_NONE,
        BR_EQ,
        BR_NE,
        BR_LEZ,
        BR_GTZ,
        BR_LTZ,
        BR_GEZ,
        BR_J,
        BR_JR
    } br_kind_e;

    // Counter constants for the default 2-bit predictor. The top level
    // derives the same encodings for wider counters: weakly-taken for new
    // conditional branches, strongly-taken for jumps, weakly-not-taken at reset.
    localparam logic [1:0] CNT_INIT_BR = 2'b10;
    localparam logic [1:0] CNT_INIT_J  = 2'b11;
    localparam logic [1:0] CNT_RESET   = 2'b01;

    function automatic logic is_jump_kind(input br_kind_e kind);
        return (kind == BR_J) || (kind == BR_JR);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational EX-stage decode of the MIPS-I branch/jump set:
// classifies the instruction, evaluates the taken condition and forms the
// actual target address.
// Ports:
//   i_instruction  EX instruction word
//   i_pc_plus4     EX PC+4
//   i_rs_data      forwarded rs
//   i_rt_data      forwarded rt
//   i_sign_ext     sign-extended immediate
//   o_kind         branch kind (BR_NONE for non-control-flow)
//   o_taken        actual taken outcome
//   o_target       actual target (only meaningful when taken)
// ---------------------------------------------------------------------------
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    input  logic [31:0] i_sign_ext,
    output br_kind_e    o_kind,
    output logic        o_taken,
    output logic [31:0] o_target
);

    logic [5:0]  w_opcode;
    logic [4:0]  w_rt;
    logic [5:0]  w_funct;
    logic        w_rs_zero;
    logic        w_rs_neg;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    br_kind_e    w_kind;

    assign w_opcode  = i_instruction[31:26];
    assign w_rt      = i_instruction[20:16];
    assign w_funct   = i_instruction[5:0];
    assign w_rs_zero = (i_rs_data == 32'd0);
    assign w_rs_neg  = i_rs_data[31];

    assign w_br_target = i_pc_plus4 + (i_sign_ext << 2);
    assign w_j_target  = {i_pc_plus4[31:28], i_instruction[25:0], 2'b00};

    always_comb begin
        w_kind = BR_NONE;
        case (w_opcode)
            OP_BEQ:     w_kind = BR_EQ;
            OP_BNE:     w_kind = BR_NE;
            OP_BLEZ:    w_kind = BR_LEZ;
            OP_BGTZ:    w_kind = BR_GTZ;
            OP_REGIMM: begin
                if (w_rt == RT_BLTZ)
                    w_kind = BR_LTZ;
                else if (w_rt == RT_BGEZ)
                    w_kind = BR_GEZ;
            end
            OP_J,
            OP_JAL:     w_kind = BR_J;
            OP_SPECIAL: begin
                if ((w_funct == FN_JR) || (w_funct == FN_JALR))
                    w_kind = BR_JR;
            end
            default:    w_kind = BR_NONE;
        endcase
    end

    // Signed compares against zero reduce to sign bit / zero detect.
    always_comb begin
        o_taken  = 1'b0;
        o_target = i_pc_plus4;
        case (w_kind)
            BR_EQ:  begin o_taken = (i_rs_data == i_rt_data); o_target = w_br_target; end
            BR_NE:  begin o_taken = (i_rs_data != i_rt_data); o_target = w_br_target; end
            BR_LEZ: begin o_taken = w_rs_neg || w_rs_zero;    o_target = w_br_target; end
            BR_GTZ: begin o_taken = !w_rs_neg && !w_rs_zero;  o_target = w_br_target; end
            BR_LTZ: begin o_taken = w_rs_neg;                 o_target = w_br_target; end
            BR_GEZ: begin o_taken = !w_rs_neg;                o_target = w_br_target; end
            BR_J:   begin o_taken = 1'b1;                     o_target = w_j_target;  end
            BR_JR:  begin o_taken = 1'b1;                     o_target = i_rs_data;   end
            default: begin o_taken = 1'b0;                    o_target = i_pc_plus4;  end
        endcase
    end

    assign o_kind = w_kind;

endmodule

// File: rtl/branch_predict_resolve.sv
// ---------------------------------------------------------------------------
// branch_predict_resolve
// Direct-mapped BTB with saturating counters for IF-stage prediction, plus
// EX-stage resolution of branches/jumps with a registered redirect/flush.
// Ports:
//   clk, reset        clock, async active-high reset
//   if_pc             fetch PC for BTB lookup
//   pred_taken        comb: BTB hit and counter MSB set
//   pred_target       comb: BTB target on hit, else 0
//   ex_*              EX-stage instruction, operands and carried prediction
//   redirect, flush   registered one-cycle pulse on mispredict
//   redirect_pc       registered corrected fetch address (holds otherwise)
//   mispredict_count  saturating redirect counter
// ---------------------------------------------------------------------------
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int BTB_DEPTH  = 16,
    parameter int CNT_W      = 2,
    parameter int MISS_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           if_pc,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_instruction,
    input  logic [31:0]           ex_pc_plus4,
    input  logic [31:0]           ex_rs_data,
    input  logic [31:0]           ex_rt_data,
    input  logic [31:0]           ex_sign_ext,
    input  logic                  ex_pred_taken,
    input  logic [31:0]           ex_pred_target,
    output logic                  redirect,
    output logic [31:0]           redirect_pc,
    output logic                  flush,
    output logic [MISS_CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [CNT_W-1:0] L_CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] L_CNT_INIT_J  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] L_CNT_INIT_BR = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] L_CNT_RESET   = L_CNT_INIT_BR - CNT_W'(1);

    // BTB storage
    logic [BTB_DEPTH-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag    [BTB_DEPTH];
    logic [31:0]          r_target [BTB_DEPTH];
    logic [CNT_W-1:0]     r_cnt    [BTB_DEPTH];

    // Output registers
    logic                  r_redirect;
    logic [31:0]           r_redirect_pc;
    logic [MISS_CNT_W-1:0] r_miss_cnt;

    // Lookup
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;

    // Resolve / update
    br_kind_e         w_kind;
    logic             w_taken;
    logic [31:0]      w_target;
    logic [31:0]      w_upd_pc;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_is_ctl;
    logic             w_is_jump;
    logic             w_invalidate;
    logic             w_mispred;
    logic [CNT_W-1:0] w_cnt_cur;
    logic [3:0]       w_unused_bits;

    assign w_unused_bits = {if_pc[1:0], w_upd_pc[1:0]};

    // ---------------- IF-stage lookup (reads pre-update state) ------------
    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[31:IDX_W+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    assign pred_taken  = w_if_hit && r_cnt[w_if_idx][CNT_W-1];
    assign pred_target = w_if_hit ? r_target[w_if_idx] : 32'd0;

    // ---------------- EX-stage resolution ---------------------------------
    branch_cond_eval u_cond_eval (
        .i_instruction (ex_instruction),
        .i_pc_plus4    (ex_pc_plus4),
        .i_rs_data     (ex_rs_data),
        .i_rt_data     (ex_rt_data),
        .i_sign_ext    (ex_sign_ext),
        .o_kind        (w_kind),
        .o_taken       (w_taken),
        .o_target      (w_target)
    );

    assign w_upd_pc  = ex_pc_plus4 - 32'd4;
    assign w_upd_idx = w_upd_pc[IDX_W+1:2];
    assign w_upd_tag = w_upd_pc[31:IDX_W+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_cnt_cur = r_cnt[w_upd_idx];

    assign w_is_ctl  = (w_kind != BR_NONE);
    assign w_is_jump = is_jump_kind(w_kind);

    // A non-control-flow instruction that was predicted taken means the
    // indexed entry steered fetch wrongly; drop it whatever its tag.
    assign w_invalidate = !w_is_ctl && ex_pred_taken;

    // An NCF predicted taken is covered by the direction check (taken = 0).
    assign w_mispred = ex_valid &&
                       ((w_taken != ex_pred_taken) ||
                        (w_taken && (w_target != ex_pred_target)));

    // ---------------- BTB valid / counter update --------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < BTB_DEPTH; i++)
                r_cnt[i] <= L_CNT_RESET;
        end else if (ex_valid) begin
            if (w_invalidate) begin
                r_valid[w_upd_idx] <= 1'b0;
            end else if (w_is_ctl) begin
                if (w_taken) begin
                    if (w_upd_hit) begin
                        if (w_cnt_cur != L_CNT_MAX)
                            r_cnt[w_upd_idx] <= w_cnt_cur + CNT_W'(1);
                    end else begin
                        r_valid[w_upd_idx] <= 1'b1;
                        r_cnt[w_upd_idx]   <= w_is_jump ? L_CNT_INIT_J : L_CNT_INIT_BR;
                    end
                end else if (w_upd_hit) begin
                    if (w_cnt_cur != '0)
                        r_cnt[w_upd_idx] <= w_cnt_cur - CNT_W'(1);
                end
            end
        end
    end

    // Tag and target need no reset: they are only observed through r_valid.
    // On a hit the tag rewrite is a no-op; on a miss it allocates.
    always_ff @(posedge clk) begin
        if (ex_valid && w_is_ctl && w_taken) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= w_target;
        end
    end

    // ---------------- Redirect / statistics -------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
            r_miss_cnt    <= '0;
        end else begin
            r_redirect <= w_mispred;
            if (w_mispred) begin
                r_redirect_pc <= w_taken ? w_target : ex_pc_plus4;
                if (r_miss_cnt != {MISS_CNT_W{1'b1}})
                    r_miss_cnt <= r_miss_cnt + MISS_CNT_W'(1);
            end
        end
    end

    assign redirect         = r_redirect;
    assign flush            = r_redirect;
    assign redirect_pc      = r_redirect_pc;
    assign mispredict_count = r_miss_cnt;

endmodule
